// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding
// and port-select constants used by the top and the round-robin picker.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester selector holding the last-granted flag.
// Ports: clock, reset (async, active-low), req_a, req_b, update
// (arbitration edge), pick (PORT_A/PORT_B). DMEM_ARB_FIXED_PRIO_EN
// selects fixed priority to A; otherwise round-robin.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic req_a,
   input  logic req_b,
   input  logic update,
   output logic pick
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

   assign pick = req_a ? PORT_A : PORT_B;

`else

   logic last;

   // Reset to B so that A wins the first contention.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last <= PORT_B;
      end else if (update) begin
         last <= pick;
      end
   end

   always_comb begin
      pick = PORT_A;
      if (req_a && req_b) begin
         pick = (last == PORT_A) ? PORT_B : PORT_A;
      end else if (req_b) begin
         pick = PORT_B;
      end
   end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU A, loader/debug B) data-memory arbiter, IDLE/ISSUE/DONE.
// Ports: clock, reset (async, active-low); per port req/we/addr/wdata in,
// gnt/done/rdata out; dmemaddr/dmemwdata/dmemwrite/dmemread to memory,
// dmemrdata back. Macro DMEM_ARB_FIXED_PRIO_EN: A always wins contention.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [DW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_done,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [DW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_done,
   output logic [DW-1:0] b_rdata,
   output logic [DW-1:0] dmemaddr,
   output logic [DW-1:0] dmemwdata,
   output logic          dmemwrite,
   output logic          dmemread,
   input  logic [DW-1:0] dmemrdata
);

   state_t        state;
   logic          pick;
   logic          arb;
   logic          sel_we;
   logic [DW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Requests are only looked at in IDLE or DONE.
   assign arb = (a_req || b_req) && (state != ISSUE);

   rr_pick2 u_pick (
      .clock  (clock),
      .reset  (reset),
      .req_a  (a_req),
      .req_b  (b_req),
      .update (arb),
      .pick   (pick)
   );

   always_comb begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
      if (pick == PORT_B) begin
         sel_we    = b_we;
         sel_addr  = b_addr;
         sel_wdata = b_wdata;
      end
   end

   // Memory-side registers double as the latched request; they are only
   // nonzero during ISSUE, and the registered gnt/read flags tell ISSUE
   // which port and direction it is serving.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         a_done    <= 1'b0;
         b_done    <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         dmemaddr  <= '0;
         dmemwdata <= '0;
         dmemwrite <= 1'b0;
         dmemread  <= 1'b0;
      end else begin
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         a_done    <= 1'b0;
         b_done    <= 1'b0;
         dmemaddr  <= '0;
         dmemwdata <= '0;
         dmemwrite <= 1'b0;
         dmemread  <= 1'b0;
         unique case (state)
            ISSUE: begin
               state <= DONE;
               if (b_gnt) begin
                  b_done <= 1'b1;
                  if (dmemread) b_rdata <= dmemrdata;
               end else begin
                  a_done <= 1'b1;
                  if (dmemread) a_rdata <= dmemrdata;
               end
            end
            IDLE, DONE: begin
               if (arb) begin
                  state     <= ISSUE;
                  a_gnt     <= (pick == PORT_A);
                  b_gnt     <= (pick == PORT_B);
                  dmemaddr  <= sel_addr;
                  dmemwdata <= sel_wdata;
                  dmemwrite <= sel_we;
                  dmemread  <= !sel_we;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected
// grants/completions; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          a_req = 1'b0, a_we = 1'b0;
   logic [DW-1:0] a_addr = '0, a_wdata = '0;
   logic          a_gnt, a_done;
   logic [DW-1:0] a_rdata;
   logic          b_req = 1'b0, b_we = 1'b0;
   logic [DW-1:0] b_addr = '0, b_wdata = '0;
   logic          b_gnt, b_done;
   logic [DW-1:0] b_rdata;
   logic [DW-1:0] dmemaddr, dmemwdata, dmemrdata;
   logic          dmemwrite, dmemread;

   dmem_arbiter #(.DW(DW)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
      .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
      .dmemwrite(dmemwrite), .dmemread(dmemread),
      .dmemrdata(dmemrdata)
   );

   always #5 clock = ~clock;

   logic [DW-1:0] mem [256];
   assign dmemrdata = mem[dmemaddr[7:0]];
   always @(posedge clock) if (dmemwrite) mem[dmemaddr[7:0]] <= dmemwdata;

   typedef struct {
      logic          port;
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t gq[$];
   exp_t dq[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_gnt_cyc = -10;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_txn(input logic p, input logic we,
                             input logic [DW-1:0] addr,
                             input logic [DW-1:0] wdata,
                             input logic [DW-1:0] rdata);
      exp_t e;
      e.port = p; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
      gq.push_back(e);
      dq.push_back(e);
   endtask

   // Monitor: every negedge, compare grants/completions to the scoreboard.
   always @(negedge clock) begin
      exp_t e;
      cyc++;
      chk("gnt_exclusive", {31'd0, a_gnt && b_gnt}, 32'd0);
      if (a_gnt || b_gnt) begin
         if (gq.size() == 0) begin
            chk("gnt_unexpected", {31'd0, b_gnt}, 32'hFFFF_FFFF);
         end else begin
            e = gq.pop_front();
            chk("gnt_port", {31'd0, b_gnt}, {31'd0, e.port});
            chk("gnt_addr", {16'd0, dmemaddr}, {16'd0, e.addr});
            chk("gnt_write", {31'd0, dmemwrite}, {31'd0, e.we});
            chk("gnt_read", {31'd0, dmemread}, {31'd0, !e.we});
            if (e.we) chk("gnt_wdata", {16'd0, dmemwdata}, {16'd0, e.wdata});
         end
         last_gnt_cyc = cyc;
      end else begin
         chk("idle_mem_zero",
             {dmemaddr, dmemwdata[13:0], dmemwrite, dmemread}, 32'd0);
      end
      if (a_done || b_done) begin
         chk("done_exclusive", {31'd0, a_done && b_done}, 32'd0);
         if (dq.size() == 0) begin
            chk("done_unexpected", {31'd0, b_done}, 32'hFFFF_FFFF);
         end else begin
            e = dq.pop_front();
            chk("done_port", {31'd0, b_done}, {31'd0, e.port});
            chk("done_latency", cyc, last_gnt_cyc + 1);
            if (!e.we)
               chk("done_rdata", {16'd0, e.port ? b_rdata : a_rdata},
                   {16'd0, e.rdata});
         end
      end
   end

   // Issue one request on a port and wait for its grant (called at negedge).
   task automatic txn(input logic p, input logic we,
                      input logic [DW-1:0] addr,
                      input logic [DW-1:0] wdata, input bit keep);
      int k;
      if (p) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      end
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!(p ? b_gnt : a_gnt) && k < 50);
      if (k >= 50) chk("gnt_timeout", {31'd0, p}, 32'hFFFF_FFFF);
      if (!keep) begin
         if (p) b_req = 1'b0;
         else a_req = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 16'h1234;

      // Reset state
      idle(2);
      chk("rst_gnt_done", {28'd0, a_gnt, b_gnt, a_done, b_done}, 32'd0);
      chk("rst_a_rdata", {16'd0, a_rdata}, 32'd0);
      chk("rst_b_rdata", {16'd0, b_rdata}, 32'd0);
      reset = 1'b1;
      idle(1);

      // Single read on A
      expect_txn(1'b0, 1'b0, 16'h0010, 16'h0, 16'h1234);
      txn(1'b0, 1'b0, 16'h0010, 16'h0, 1'b0);
      idle(3);
      chk("a_rdata_read", {16'd0, a_rdata}, 32'h1234);

      // Write then read on B
      expect_txn(1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0);
      txn(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0);
      idle(2);
      expect_txn(1'b1, 1'b0, 16'h0020, 16'h0, 16'hBEEF);
      txn(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
      idle(3);
      chk("b_rdata_read", {16'd0, b_rdata}, 32'hBEEF);
      chk("a_rdata_hold", {16'd0, a_rdata}, 32'h1234);

      // Contention, both ports back to back
`ifdef DMEM_ARB_FIXED_PRIO_EN
      expect_txn(1'b0, 1'b0, 16'h0010, 16'h0, 16'h1234);
      expect_txn(1'b0, 1'b1, 16'h0030, 16'h5555, 16'h0);
      expect_txn(1'b1, 1'b0, 16'h0020, 16'h0, 16'hBEEF);
      expect_txn(1'b1, 1'b0, 16'h0030, 16'h0, 16'h5555);
`else
      expect_txn(1'b0, 1'b0, 16'h0010, 16'h0, 16'h1234);
      expect_txn(1'b1, 1'b0, 16'h0020, 16'h0, 16'hBEEF);
      expect_txn(1'b0, 1'b1, 16'h0030, 16'h5555, 16'h0);
      expect_txn(1'b1, 1'b0, 16'h0030, 16'h0, 16'h5555);
`endif
      fork
         begin
            txn(1'b0, 1'b0, 16'h0010, 16'h0, 1'b1);
            txn(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0);
         end
         begin
            txn(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
            txn(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0);
         end
      join
      idle(3);

      // All-ones address passes through unchanged
      expect_txn(1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0);
      txn(1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 1'b0);
      idle(1);
      expect_txn(1'b0, 1'b0, 16'hFFFF, 16'h0, 16'hA5A5);
      txn(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b0);
      idle(3);
      chk("a_rdata_ones", {16'd0, a_rdata}, 32'hA5A5);
      chk("b_rdata_hold", {16'd0, b_rdata}, 32'h5555);

      // Reset during ISSUE aborts the transaction (no done expected)
      begin
         exp_t e;
         e.port = 1'b1; e.we = 1'b0; e.addr = 16'h0010;
         e.wdata = 16'h0; e.rdata = 16'h0;
         gq.push_back(e);
      end
      txn(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("abort_enables", {30'd0, dmemwrite, dmemread}, 32'd0);
      chk("abort_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      chk("abort_b_rdata", {16'd0, b_rdata}, 32'd0);
      idle(3);
      reset = 1'b1;
      idle(2);
      chk("abort_no_done", {30'd0, a_done, b_done}, 32'd0);

      // After reset, last-granted is B again so A wins first
      expect_txn(1'b0, 1'b0, 16'h0020, 16'h0, 16'hBEEF);
      expect_txn(1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234);
      fork
         txn(1'b0, 1'b0, 16'h0020, 16'h0, 1'b0);
         txn(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
      join
      idle(4);

      chk("gq_drained", gq.size(), 32'd0);
      chk("dq_drained", dq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
